// File: rtl/comet2_boot_loader_if.sv
// Byte-stream handshake into the COMET II boot loader.
// The producer drives valid/data and the loader answers with ready.
interface comet2_boot_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/comet2_boot_loader.sv
// COMET II program loader: assembles a big-endian byte stream into RAM words while the CPU
// is held in reset, then releases it with an init pulse and passes the CPU RAM port through.
module comet2_boot_loader #(
    parameter bit HOLD_AFTER_RESET = 1'b1
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        load_req,
    comet2_boot_loader_if.slave strm,
    output logic        cpu_hold,
    output logic        cpu_init,
    output logic [15:0] boot_pr,
    output logic        busy,
    output logic [15:0] words_loaded,
    input  logic        cpu_re,
    input  logic [15:0] cpu_raddr,
    input  logic        cpu_we,
    input  logic [15:0] cpu_waddr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        ram_re,
    output logic [15:0] ram_raddr,
    output logic        ram_we,
    output logic [15:0] ram_waddr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR_A = 3'd1,
        HDR_L = 3'd2,
        DATA  = 3'd3,
        BOOT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] boot_pr_q, boot_pr_d;
    logic [15:0] wp_q, wp_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        cpu_init_q, cpu_init_d;
    logic        wr_we_q, wr_we_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic        ready;
    logic        accept;
    logic [15:0] word;
    logic [15:0] wl_inc;

    assign ready  = (state_q == HDR_A) || (state_q == HDR_L) || (state_q == DATA);
    assign accept = strm.s_valid & ready;
    assign word   = {hi_q, strm.s_data};
    assign wl_inc = words_loaded_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        hi_d           = hi_q;
        boot_pr_d      = boot_pr_q;
        wp_d           = wp_q;
        cnt_d          = cnt_q;
        words_loaded_d = words_loaded_q;
        cpu_hold_d     = cpu_hold_q;
        cpu_init_d     = 1'b0;
        wr_we_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d        = HDR_A;
                    cpu_hold_d     = 1'b1;
                    words_loaded_d = 16'd0;
                    phase_d        = 1'b0;
                end
            end
            HDR_A: begin
                if (accept) begin
                    if (!phase_q) begin
                        hi_d    = strm.s_data;
                        phase_d = 1'b1;
                    end else begin
                        boot_pr_d = word;
                        wp_d      = word;
                        phase_d   = 1'b0;
                        state_d   = HDR_L;
                    end
                end
            end
            HDR_L: begin
                if (accept) begin
                    if (!phase_q) begin
                        hi_d    = strm.s_data;
                        phase_d = 1'b1;
                    end else begin
                        cnt_d   = word;
                        phase_d = 1'b0;
                        if (word == 16'd0) begin
                            state_d    = BOOT;
                            cpu_hold_d = 1'b0;
                            cpu_init_d = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (!phase_q) begin
                        hi_d    = strm.s_data;
                        phase_d = 1'b1;
                    end else begin
                        // The word is written the cycle after its low byte lands.
                        wr_we_d        = 1'b1;
                        wr_addr_d      = wp_q;
                        wr_data_d      = word;
                        wp_d           = wp_q + 16'd1;
                        words_loaded_d = wl_inc;
                        phase_d        = 1'b0;
                        if (wl_inc == cnt_q) begin
                            state_d    = BOOT;
                            cpu_hold_d = 1'b0;
                            cpu_init_d = 1'b1;
                        end
                    end
                end
            end
            BOOT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            phase_q        <= 1'b0;
            hi_q           <= 8'h00;
            boot_pr_q      <= 16'h0000;
            wp_q           <= 16'h0000;
            cnt_q          <= 16'h0000;
            words_loaded_q <= 16'h0000;
            cpu_hold_q     <= HOLD_AFTER_RESET;
            cpu_init_q     <= 1'b0;
            wr_we_q        <= 1'b0;
            wr_addr_q      <= 16'h0000;
            wr_data_q      <= 16'h0000;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            boot_pr_q      <= boot_pr_d;
            wp_q           <= wp_d;
            cnt_q          <= cnt_d;
            words_loaded_q <= words_loaded_d;
            cpu_hold_q     <= cpu_hold_d;
            cpu_init_q     <= cpu_init_d;
            wr_we_q        <= wr_we_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    // A pending loader write wins even in the BOOT cycle, when the CPU is already released.
    logic loader_sel;
    assign loader_sel = cpu_hold_q | wr_we_q;

    assign ram_we    = loader_sel ? wr_we_q   : cpu_we;
    assign ram_waddr = loader_sel ? wr_addr_q : cpu_waddr;
    assign ram_wdata = loader_sel ? wr_data_q : cpu_wdata;

    assign ram_re    = cpu_re;
    assign ram_raddr = cpu_raddr;
    assign cpu_rdata = ram_rdata;

    assign strm.s_ready = ready;
    assign busy         = ready;
    assign cpu_hold     = cpu_hold_q;
    assign cpu_init     = cpu_init_q;
    assign boot_pr      = boot_pr_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_comet2_boot_loader.sv
// Bench for comet2_boot_loader: a negedge monitor pops expected RAM writes from a queue
// filled as stream bytes are driven; each scenario task checks control outputs inline.
module tb_comet2_boot_loader;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        cpu_hold, cpu_init, busy;
    logic [15:0] boot_pr, words_loaded;
    logic        cpu_re = 1'b0;
    logic [15:0] cpu_raddr = 16'h0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_waddr = 16'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        ram_re, ram_we;
    logic [15:0] ram_raddr, ram_waddr, ram_wdata;
    logic [15:0] ram_rdata = 16'h0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_drop = 0;
    bit          mon_en = 1'b1;
    logic [31:0] exp_q[$];

    comet2_boot_loader_if iface();

    comet2_boot_loader #(.HOLD_AFTER_RESET(1'b1)) dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .load_req     (load_req),
        .strm         (iface),
        .cpu_hold     (cpu_hold),
        .cpu_init     (cpu_init),
        .boot_pr      (boot_pr),
        .busy         (busy),
        .words_loaded (words_loaded),
        .cpu_re       (cpu_re),
        .cpu_raddr    (cpu_raddr),
        .cpu_we       (cpu_we),
        .cpu_waddr    (cpu_waddr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .ram_re       (ram_re),
        .ram_raddr    (ram_raddr),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 mclk = ~mclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for loader writes
    always @(negedge mclk) begin
        if (rst_n && mon_en && ram_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ram_waddr, ram_wdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({ram_waddr, ram_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_waddr, ram_wdata, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            int n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                iface.s_valid = 1'b0;
                if (iface.s_ready !== 1'b1) ready_drop++;
                @(posedge mclk); #1;
            end
        end
        iface.s_valid = 1'b1;
        iface.s_data  = b;
        while (iface.s_ready !== 1'b1 && guard < 50) begin
            @(posedge mclk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: s_ready=%b after %0d cycles, required 1", iface.s_ready, guard);
        end
        @(posedge mclk); #1;
        iface.s_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge mclk); #1;
        load_req = 1'b0;
    endtask

    // Drives header and words; returns one step after the edge accepting the last byte.
    task automatic run_load(input logic [15:0] a, input logic [15:0] w[$], input bit gaps);
        logic [15:0] n;
        logic [15:0] addr;
        n = 16'(w.size());
        pulse_load_req();
        send_byte(a[15:8], gaps);
        send_byte(a[7:0], gaps);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int i = 0; i < w.size(); i++) begin
            addr = a + 16'(i);
            exp_q.push_back({addr, w[i]});
            send_byte(w[i][15:8], gaps);
            send_byte(w[i][7:0], gaps);
        end
    endtask

    task automatic test_reset();
        cpu_we = 1'b1; cpu_waddr = 16'h0EEE; cpu_wdata = 16'hDEAD;
        repeat (2) @(posedge mclk);
        #1;
        n_checks++; if (iface.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b required 0", iface.s_ready); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); end
        n_checks++; if (cpu_init !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_init_busy: got %b%b required 00", cpu_init, busy); end
        n_checks++; if (boot_pr !== 16'h0 || words_loaded !== 16'h0) begin n_fail++; $display("FAIL rst_regs: got pr=%h wl=%h required 0000 0000", boot_pr, words_loaded); end
        n_checks++; if (ram_we !== 1'b0 || ram_waddr !== 16'h0 || ram_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wport: got we=%b a=%h d=%h required 0 0000 0000", ram_we, ram_waddr, ram_wdata); end
        rst_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        n_checks++; if (cpu_hold !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL hold_after_reset: got hold=%b we=%b required 1 0", cpu_hold, ram_we); end
        cpu_we = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] w[$];
        w = {16'h1234, 16'hABCD};
        load_req = 1'b1;
        @(posedge mclk); #1;
        load_req = 1'b0;
        n_checks++; if (cpu_hold !== 1'b1 || busy !== 1'b1 || iface.s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_start: got hold=%b busy=%b rdy=%b required 111", cpu_hold, busy, iface.s_ready); end
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({16'h0100 + 16'(i), w[i]});
            send_byte(w[i][15:8], 1'b0);
            send_byte(w[i][7:0], 1'b0);
        end
        n_checks++; if (cpu_init !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_boot: got init=%b hold=%b required 1 0", cpu_init, cpu_hold); end
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 16'h0101) begin n_fail++; $display("FAIL basic_last_write: got we=%b a=%h required 1 0101", ram_we, ram_waddr); end
        @(posedge mclk); #1;
        n_checks++; if (cpu_init !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_init_pulse: got init=%b busy=%b required 0 0", cpu_init, busy); end
        n_checks++; if (boot_pr !== 16'h0100 || words_loaded !== 16'd2) begin n_fail++; $display("FAIL basic_result: got pr=%h wl=%0d required 0100 2", boot_pr, words_loaded); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_pending: got %0d writes outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_zero_count();
        logic [15:0] w[$];
        w = {};
        run_load(16'h0010, w, 1'b0);
        n_checks++; if (cpu_init !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL zero_boot: got init=%b we=%b required 1 0", cpu_init, ram_we); end
        n_checks++; if (boot_pr !== 16'h0010 || words_loaded !== 16'd0) begin n_fail++; $display("FAIL zero_regs: got pr=%h wl=%0d required 0010 0", boot_pr, words_loaded); end
        load_req = 1'b1;
        @(posedge mclk); #1;
        load_req = 1'b0;
        n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL boot_ignores_req: got busy=%b hold=%b required 0 0", busy, cpu_hold); end
    endtask

    task automatic test_wrap();
        logic [15:0] w[$];
        w = {16'h1111, 16'h2222};
        run_load(16'hFFFF, w, 1'b0);
        @(posedge mclk); #1;
        n_checks++; if (boot_pr !== 16'hFFFF || words_loaded !== 16'd2 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_result: got pr=%h wl=%0d pending=%0d required FFFF 2 0", boot_pr, words_loaded, exp_q.size()); end
    endtask

    task automatic test_stalled();
        logic [15:0] w[$];
        w = {16'($urandom), 16'($urandom), 16'($urandom)};
        ready_drop = 0;
        run_load(16'h0300, w, 1'b1);
        n_checks++; if (cpu_init !== 1'b1) begin n_fail++; $display("FAIL stall_boot: got init=%b required 1", cpu_init); end
        @(posedge mclk); #1;
        n_checks++; if (ready_drop != 0) begin n_fail++; $display("FAIL stall_ready: got %0d gap cycles without s_ready required 0", ready_drop); end
        n_checks++; if (words_loaded !== 16'd3 || exp_q.size() != 0) begin n_fail++; $display("FAIL stall_result: got wl=%0d pending=%0d required 3 0", words_loaded, exp_q.size()); end
    endtask

    task automatic test_passthrough();
        logic [15:0] w[$];
        mon_en = 1'b0;
        cpu_we = 1'b1; cpu_waddr = 16'h0200; cpu_wdata = 16'h5555;
        cpu_re = 1'b1; cpu_raddr = 16'h1234; ram_rdata = 16'hBEEF;
        #1;
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 16'h0200 || ram_wdata !== 16'h5555) begin n_fail++; $display("FAIL pass_write: got we=%b a=%h d=%h required 1 0200 5555", ram_we, ram_waddr, ram_wdata); end
        n_checks++; if (ram_re !== 1'b1 || ram_raddr !== 16'h1234 || cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL pass_read: got re=%b a=%h d=%h required 1 1234 BEEF", ram_re, ram_raddr, cpu_rdata); end
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(posedge mclk); #1;
        mon_en = 1'b1;
        w = {16'h7777};
        pulse_load_req();
        cpu_we = 1'b1; cpu_waddr = 16'h0EEE; cpu_wdata = 16'hDEAD;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL hold_masks_cpu: got we=%b required 0", ram_we); end
        send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        exp_q.push_back({16'h0400, w[0]});
        send_byte(8'h77, 1'b0); send_byte(8'h77, 1'b0);
        n_checks++; if (cpu_hold !== 1'b0 || ram_waddr !== 16'h0400 || ram_wdata !== 16'h7777) begin n_fail++; $display("FAIL boot_priority: got hold=%b a=%h d=%h required 0 0400 7777", cpu_hold, ram_waddr, ram_wdata); end
        cpu_we = 1'b0;
        @(posedge mclk); #1;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL priority_pending: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midword();
        logic [15:0] w[$];
        pulse_load_req();
        send_byte(8'h00, 1'b0); send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_hold !== 1'b1 || iface.s_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midword_reset: got hold=%b rdy=%b busy=%b required 1 0 0", cpu_hold, iface.s_ready, busy); end
        @(posedge mclk); #1;
        n_checks++; if (ram_we !== 1'b0 || boot_pr !== 16'h0) begin n_fail++; $display("FAIL midword_drop: got we=%b pr=%h required 0 0000", ram_we, boot_pr); end
        rst_n = 1'b1;
        @(posedge mclk); #1;
        w = {16'hCAFE, 16'hF00D};
        run_load(16'h0500, w, 1'b0);
        n_checks++; if (cpu_init !== 1'b1 || ram_waddr !== 16'h0501) begin n_fail++; $display("FAIL reload_boot: got init=%b a=%h required 1 0501", cpu_init, ram_waddr); end
        @(posedge mclk); #1;
        n_checks++; if (boot_pr !== 16'h0500 || words_loaded !== 16'd2 || exp_q.size() != 0) begin n_fail++; $display("FAIL reload_result: got pr=%h wl=%0d pending=%0d required 0500 2 0", boot_pr, words_loaded, exp_q.size()); end
    endtask

    initial begin
        iface.s_valid = 1'b0;
        iface.s_data  = 8'h00;
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_stalled();
        test_passthrough();
        test_reset_midword();
        repeat (3) @(posedge mclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
